// File: rtl/button_event_gen.sv
// Turns a debounced pushbutton level into single-cycle press / release / short-click /
// long-press / auto-repeat events plus a "held" level for the alarm-clock control FSM.
module button_event_gen #(
  parameter int TICK_DIV     = 100000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable_i,
  input  logic btn_i,
  output logic press_o,
  output logic release_o,
  output logic short_click_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic held_o
);

  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] LONG_CNT   = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] REPEAT_CNT = HOLD_W'(REPEAT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } state_e;

  state_e              state_q;
  logic                btn_q;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                press_q, release_q, short_click_q, long_press_q, repeat_q, held_q;
  logic                rise, fall, tick_wrap;

  assign rise      = btn_i & ~btn_q;
  assign fall      = ~btn_i & btn_q;
  assign tick_wrap = (tick_q == TICK_LAST);

  // Free-running hold timer; the FSM decides whether these values are kept.
  always_comb begin
    tick_d = tick_q + 1'b1;
    hold_d = hold_q;
    if (tick_wrap) begin
      tick_d = '0;
      hold_d = hold_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch below
  // sees the pre-edge values of all registers regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      btn_q         <= 1'b1;  // a button held through reset must be released before it can press
      tick_q        <= '0;
      hold_q        <= '0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      short_click_q <= 1'b0;
      long_press_q  <= 1'b0;
      repeat_q      <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      btn_q         <= btn_i;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      short_click_q <= 1'b0;
      long_press_q  <= 1'b0;
      repeat_q      <= 1'b0;

      if (!enable_i) begin
        state_q <= S_IDLE;
        tick_q  <= '0;
        hold_q  <= '0;
        held_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            tick_q <= '0;
            hold_q <= '0;
            if (rise) begin
              state_q <= S_PRESSED;
              press_q <= 1'b1;
            end
          end

          S_PRESSED: begin
            if (fall) begin
              state_q       <= S_IDLE;
              release_q     <= 1'b1;
              short_click_q <= 1'b1;
              tick_q        <= '0;
              hold_q        <= '0;
            end else if (tick_wrap && hold_d == LONG_CNT) begin
              state_q      <= S_HELD;
              long_press_q <= 1'b1;
              held_q       <= 1'b1;
              tick_q       <= '0;
              hold_q       <= '0;
            end else begin
              tick_q <= tick_d;
              hold_q <= hold_d;
            end
          end

          S_HELD: begin
            if (fall) begin
              state_q   <= S_IDLE;
              release_q <= 1'b1;
              held_q    <= 1'b0;
              tick_q    <= '0;
              hold_q    <= '0;
            end else if (tick_wrap && hold_d == REPEAT_CNT) begin
              repeat_q <= 1'b1;
              tick_q   <= '0;
              hold_q   <= '0;
            end else begin
              tick_q <= tick_d;
              hold_q <= hold_d;
            end
          end

          default: begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            hold_q  <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign press_o       = press_q;
  assign release_o     = release_q;
  assign short_click_o = short_click_q;
  assign long_press_o  = long_press_q;
  assign repeat_o      = repeat_q;
  assign held_o        = held_q;

endmodule
